// File: rtl/mult_div_unit.sv
// mult_div_unit
//   E-stage multiply/divide unit that owns the architectural HI/LO registers.
//   mult/multu/div/divu compute their result when Start is seen and hold it
//   in pend_hi/pend_lo. HI/LO are committed when the busy countdown expires.
//   mthi/mtlo write HI/LO directly, but only while idle.
//
//   state | meaning
//   IDLE  | cnt == 0, accepts Start and mthi/mtlo
//   RUN   | cnt != 0, counting down to the HI/LO commit
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   Start  in   single-cycle pulse: E-stage instr is mult/multu/div/divu
//   MDOp   in   [1:0] 00 mult, 01 multu, 10 div, 11 divu
//   D1     in   [31:0] rs operand; also write data for mthi/mtlo
//   D2     in   [31:0] rt operand
//   mtHI   in   E-stage instr is mthi
//   mtLO   in   E-stage instr is mtlo
//   Busy   out  operation in progress
//   HI     out  [31:0] architectural HI
//   LO     out  [31:0] architectural LO
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        mtHI,
  input  logic        mtLO,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u, res;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_by_zero;

  // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of hitting signed overflow.
  always_comb begin
    prod_s = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    prod_u = {32'd0, D1} * {32'd0, D2};
    abs_a  = D1[31] ? (32'd0 - D1) : D1;
    abs_b  = D2[31] ? (32'd0 - D2) : D2;
    q_mag  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    r_mag  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    q_s    = (D1[31] ^ D2[31]) ? (32'd0 - q_mag) : q_mag;
    r_s    = D1[31] ? (32'd0 - r_mag) : r_mag;
    q_u    = (D2 == 32'd0) ? 32'd0 : D1 / D2;
    r_u    = (D2 == 32'd0) ? 32'd0 : D1 % D2;
    div_by_zero = MDOp[1] && (D2 == 32'd0);
    case (MDOp)
      2'b00:   res = prod_s;
      2'b01:   res = prod_u;
      2'b10:   res = {r_s, q_s};
      default: res = {r_u, q_u};
    endcase
    // Divide by zero still runs the full sequence but commits the current HI/LO.
    if (div_by_zero) res = {hi_q, lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d     = MDOp[1] ? DIV_N : MULT_N;
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          state_d   = RUN;
        end else begin
          if (mtHI) hi_d = D1;
          if (mtLO) lo_d = D1;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // The hazard unit stalls new mult/div while busy.
  a_no_start_when_busy : assert property (@(posedge clk) disable iff (reset) !(Start && Busy));

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] D1, D2;
  logic        mtHI, mtLO;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .D1(D1), .D2(D2),
    .mtHI(mtHI), .mtLO(mtLO), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: architectural result of one op from integer arithmetic.
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, sq, sr, sp;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = m_hi;
    nl = m_lo;
    case (op)
      2'b00: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; end
      2'b01: begin pu = 64'(a) * 64'(b); nh = pu[63:32]; nl = pu[31:0]; end
      2'b10: if (b != 0) begin sq = sa / sb; sr = sa % sb; nh = sr[31:0]; nl = sq[31:0]; end
      default: if (b != 0) begin nh = a % b; nl = a / b; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op; optionally pulses mthi with 0xDEAD on busy cycle mt_at.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int mt_at);
    logic [31:0] nh, nl;
    int n;
    ref_op(op, a, b, nh, nl);
    n = op[1] ? DIV_N : MULT_N;
    Start = 1'b1; MDOp = op; D1 = a; D2 = b;
    tick();
    Start = 1'b0; D1 = $urandom; D2 = $urandom;
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, 32'(Busy), 32'd1);
      check({tag, " hi_hold"}, HI, m_hi);
      check({tag, " lo_hold"}, LO, m_lo);
      if (i == mt_at) begin mtHI = 1'b1; D1 = 32'h0000DEAD; end
      tick();
      mtHI = 1'b0;
    end
    m_hi = nh; m_lo = nl;
    check({tag, " done_busy"}, 32'(Busy), 32'd0);
    check({tag, " hi"}, HI, m_hi);
    check({tag, " lo"}, LO, m_lo);
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] v);
    mtHI = wh; mtLO = wl; D1 = v;
    tick();
    mtHI = 1'b0; mtLO = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check("mt hi", HI, m_hi);
    check("mt lo", LO, m_lo);
    check("mt busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; Start = 1'b0; MDOp = 2'b00; D1 = '0; D2 = '0; mtHI = 1'b0; mtLO = 1'b0;
    tick(); tick();
    check("reset busy", 32'(Busy), 32'd0);
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);
    reset = 1'b0;

    do_op("mult", 2'b00, 32'hFFFFFFFD, 32'd5, -1);
    check("mult hi const", HI, 32'hFFFFFFFF);
    check("mult lo const", LO, 32'hFFFFFFF1);

    do_op("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("multu hi const", HI, 32'hFFFFFFFE);
    check("multu lo const", LO, 32'h00000001);

    do_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, -1);
    check("div hi const", HI, 32'hFFFFFFFF);
    check("div lo const", LO, 32'hFFFFFFFD);

    do_op("divu", 2'b11, 32'd7, 32'd2, -1);
    check("divu hi const", HI, 32'd1);
    check("divu lo const", LO, 32'd3);

    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
    check("div_ovf hi const", HI, 32'd0);
    check("div_ovf lo const", LO, 32'h80000000);

    mt_write(1'b1, 1'b0, 32'h1234);
    mt_write(1'b0, 1'b1, 32'h5678);
    do_op("divu0", 2'b11, 32'd7, 32'd0, -1);
    check("divu0 hi const", HI, 32'h1234);
    check("divu0 lo const", LO, 32'h5678);
    do_op("div0", 2'b10, 32'h80000000, 32'd0, -1);

    mt_write(1'b0, 1'b1, 32'hCAFEBABE);
    check("mtlo const", LO, 32'hCAFEBABE);
    mt_write(1'b1, 1'b1, 32'h0BADF00D);

    do_op("mthi_run", 2'b00, 32'd3, 32'd4, 1);
    check("mthi_run hi const", HI, 32'd0);
    check("mthi_run lo const", LO, 32'd12);

    // Reset on the 4th busy cycle of a divide aborts it.
    mt_write(1'b1, 1'b0, 32'h11111111);
    Start = 1'b1; MDOp = 2'b10; D1 = 32'd100; D2 = 32'd7;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset busy", 32'(Busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort hi", HI, 32'd0);
    check("abort lo", LO, 32'd0);
    repeat (DIV_N + 2) tick();
    check("post_abort busy", 32'(Busy), 32'd0);
    check("post_abort hi", HI, 32'd0);
    check("post_abort lo", LO, 32'd0);
    do_op("mult_after_reset", 2'b00, 32'h00010000, 32'h00030000, -1);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom)};
        if ($urandom_range(0, 9) == 0) a = 32'h80000000;
        do_op("rand", op, a, b, -1);
      end
      repeat ($urandom_range(0, 2)) tick();
      check("rand idle hi", HI, m_hi);
      check("rand idle lo", LO, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
